// File: rtl/mlblock_flex_pkg.sv
// Shared constants and product arithmetic for the flex MAC block.
// Operand containers are 32 bits wide, so I_W and W_W must be <= 32.
package mlblock_flex_pkg;

  localparam logic [1:0] MODE_SIGNED   = 2'd0;
  localparam logic [1:0] MODE_HALF     = 2'd1;
  localparam logic [1:0] MODE_UNSIGNED = 2'd2;

  localparam int CFG_MODE_LSB = 0;
  localparam int CFG_MODE_W   = 2;
  localparam int CFG_LEN_LSB  = 2;

  function automatic int cfg_bits(input int acc_w);
    return acc_w + 3;
  endfunction

  typedef struct packed {
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic        [31:0] u;
  } opnd_t;

  function automatic logic signed [63:0] mac_prod(
    input logic [1:0] mode,
    input opnd_t      a,
    input opnd_t      b
  );
    logic signed [63:0] r;
    r = '0;
    case (mode)
      MODE_HALF:
        r = 64'(a.hi) * 64'(b.hi)
          + 64'(a.lo) * 64'(b.lo);
      MODE_UNSIGNED:
        r = signed'({32'b0, a.u} * {32'b0, b.u});
      default:
        r = 64'(a.s) * 64'(b.s);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mlblock_flex_lane.sv
// One MAC lane: stationary weight, registered product, accumulator.
// The sum output is combinational; the top registers it.
module mlblock_flex_lane
  import mlblock_flex_pkg::*;
#(
  parameter int I_W   = 8,
  parameter int W_W   = 8,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_mode,
  input  logic [I_W-1:0]   i_in,
  input  logic             i_w_en,
  input  logic [W_W-1:0]   i_w,
  input  logic             i_s1_load,
  input  logic             i_s2_fire,
  input  logic             i_last,
  input  logic             i_flush,
  input  logic [RES_W-1:0] i_cas,
  output logic [W_W-1:0]   o_w,
  output logic [RES_W-1:0] o_sum
);

  localparam int IH = I_W / 2;
  localparam int WH = W_W / 2;

  logic [W_W-1:0]     r_w;
  logic [RES_W-1:0]   r_prod;
  logic [RES_W-1:0]   r_acc;
  opnd_t              w_a;
  opnd_t              w_b;
  logic signed [63:0] w_prod;

  always_comb begin
    w_a.s  = 32'(signed'(i_in));
    w_a.u  = 32'(i_in);
    w_a.hi = 32'(signed'(i_in[I_W-1:IH]));
    w_a.lo = 32'(signed'(i_in[IH-1:0]));
    w_b.s  = 32'(signed'(r_w));
    w_b.u  = 32'(r_w);
    w_b.hi = 32'(signed'(r_w[W_W-1:WH]));
    w_b.lo = 32'(signed'(r_w[WH-1:0]));
    w_prod = mac_prod(i_mode, w_a, w_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w <= '0;
    end else if (i_w_en) begin
      r_w <= i_w;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prod <= '0;
    end else if (i_s1_load) begin
      r_prod <= w_prod[RES_W-1:0];
    end
  end

  // Last beat restarts the accumulator; its sum leaves via o_sum.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_acc <= '0;
    end else if (i_s2_fire) begin
      r_acc <= i_last ? '0 : r_acc + r_prod;
    end
  end

  assign o_w   = r_w;
  assign o_sum = r_acc + r_prod + i_cas;

endmodule

// File: rtl/mlblock_flex_acc.sv
// Multi-lane MAC with precision modes, auto-emit accumulate length,
// valid/ready back-pressure and a shadowed config scan chain.
module mlblock_flex_acc
  import mlblock_flex_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int I_W       = 8,
  parameter int W_W       = 8,
  parameter int RES_W     = 32,
  parameter int ACC_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*I_W-1:0]   I_in,
  input  logic                   I_valid,
  output logic                   I_ready,
  input  logic [LANES*W_W-1:0]   W_in,
  input  logic                   W_en,
  output logic [LANES*W_W-1:0]   W_out,
  input  logic [LANES*RES_W-1:0] Res_cas_in,
  output logic [LANES*RES_W-1:0] Res_out,
  output logic [LANES*RES_W-1:0] Res_cas_out,
  output logic                   Res_valid,
  input  logic                   Res_ready,
  input  logic                   config_en,
  input  logic                   config_in,
  input  logic                   config_commit,
  output logic                   config_out
);

  localparam int CFG_BITS = cfg_bits(ACC_CNT_W);

  logic [CFG_BITS-1:0]    r_shadow;
  logic [CFG_BITS-1:0]    r_act;
  logic [ACC_CNT_W-1:0]   r_beat;
  logic                   r_s1_valid;
  logic                   r_s1_last;
  logic                   r_res_valid;
  logic [LANES*RES_W-1:0] r_res;

  logic [1:0]             w_mode;
  logic [ACC_CNT_W-1:0]   w_len;
  logic                   w_cas_en;
  logic                   w_adv;
  logic                   w_take;
  logic                   w_hit;
  logic                   w_s2_fire;
  logic [LANES*RES_W-1:0] w_sum;

  assign w_mode    = r_act[CFG_MODE_LSB +: CFG_MODE_W];
  assign w_len     = r_act[CFG_LEN_LSB +: ACC_CNT_W];
  assign w_cas_en  = r_act[CFG_BITS-1];
  assign w_adv     = !r_res_valid || Res_ready;
  assign w_take    = I_valid && w_adv;
  assign w_hit     = (r_beat == w_len);
  assign w_s2_fire = w_adv && r_s1_valid;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [RES_W-1:0] w_cas;
    assign w_cas = w_cas_en
      ? Res_cas_in[k*RES_W +: RES_W] : '0;
    mlblock_flex_lane #(
      .I_W   (I_W),
      .W_W   (W_W),
      .RES_W (RES_W)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .i_mode    (w_mode),
      .i_in      (I_in[k*I_W +: I_W]),
      .i_w_en    (W_en),
      .i_w       (W_in[k*W_W +: W_W]),
      .i_s1_load (w_take),
      .i_s2_fire (w_s2_fire),
      .i_last    (r_s1_last),
      .i_flush   (config_commit),
      .i_cas     (w_cas),
      .o_w       (W_out[k*W_W +: W_W]),
      .o_sum     (w_sum[k*RES_W +: RES_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (config_en) begin
      r_shadow <= {r_shadow[CFG_BITS-2:0], config_in};
    end
  end

  // Commit flushes in-flight beats; Res_out keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act       <= '0;
      r_beat      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res       <= '0;
    end else if (config_commit) begin
      r_act       <= r_shadow;
      r_beat      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_res_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= I_valid;
      if (I_valid) begin
        r_s1_last <= w_hit;
        r_beat    <= w_hit ? '0 : r_beat + 1'b1;
      end
      if (r_s1_valid && r_s1_last) begin
        r_res       <= w_sum;
        r_res_valid <= 1'b1;
      end else begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign I_ready     = w_adv;
  assign Res_out     = r_res;
  assign Res_cas_out = r_res;
  assign Res_valid   = r_res_valid;
  assign config_out  = r_shadow[CFG_BITS-1];

endmodule

// File: doc/mlblock_flex_acc.md
Name: mlblock_flex_acc

Overview:
- Parametrised multi-lane MAC block, next generation of the 2D-flex MLBlock.
- LANES lanes, each multiplying a streamed input by a stationary weight and accumulating over a programmable number of beats.
- New relative to the previous generation: runtime precision modes (signed, unsigned, dual half-width), an accumulate-length counter that emits results automatically, valid/ready back-pressure, and a shadowed config scan chain with explicit commit.
- Instances tile in a grid: weights chain through W_out, partial sums chain through Res_cas_in/Res_cas_out, config bits chain through config_in/config_out.

Parameters:
- LANES, 4, number of MAC lanes.
- I_W, 8, input operand width (must be even).
- W_W, 8, weight width (must be even).
- RES_W, 32, accumulator/result width (must be >= I_W+W_W).
- ACC_CNT_W, 4, accumulate-length field width; max length 2**ACC_CNT_W beats.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- I_in  in  LANES*I_W  lane k input at bits [(k+1)*I_W-1 : k*I_W].
- I_valid  in  1  input beat valid.
- I_ready  out  1  block accepts a beat.
- W_in  in  LANES*W_W  weights, all lanes in parallel.
- W_en  in  1  load W_in into the weight registers.
- W_out  out  LANES*W_W  registered weights, for the next block.
- Res_cas_in  in  LANES*RES_W  cascaded partial sums.
- Res_out  out  LANES*RES_W  results.
- Res_cas_out  out  LANES*RES_W  equal to Res_out.
- Res_valid  out  1  result valid.
- Res_ready  in  1  downstream accepts the result.
- config_en  in  1  shift the config chain.
- config_in  in  1  serial config bit in.
- config_commit  in  1  copy shadow config to active config.
- config_out  out  1  serial config bit out (shadow MSB).

Behaviour:
- Reset (synchronous, active-high) clears: shadow and active config, weights, pipeline valid bits, beat counter, accumulators, Res_out, Res_valid.
- After reset: I_ready=1, W_out=0, config_out=0.
- Config layout, CFG_BITS = ACC_CNT_W+3:
  - [1:0] mode: 0 signed, 1 dual-half signed, 2 unsigned, 3 reserved (behaves as 0).
  - [ACC_CNT_W+1:2] acc_len: beats per result = acc_len+1.
  - [ACC_CNT_W+2] cas_en.
- Config chain: config_en shifts shadow <= {shadow[CFG_BITS-2:0], config_in}.
- config_commit: active <= shadow, using the pre-edge shadow value when config_en is high in the same cycle.
- Commit also flushes the datapath: pipeline valid bits, beat counter and accumulators cleared; Res_valid deasserted; Res_out retains its value. Weights are not affected.
- W_en: weight regs <= W_in. Loading is legal mid-accumulation and affects beats accepted after the edge.
- Global advance: adv = !Res_valid || Res_ready. I_ready = adv. All pipeline registers hold when adv=0.
- Stage 1, on an edge with I_valid && adv:
  - Register per-lane products.
  - Tag the beat "last" when beat_cnt == acc_len.
  - beat_cnt increments, or wraps to 0 on a last beat.
- Stage 2, on an edge with adv and stage-1 valid:
  - Non-last beat: acc += prod.
  - Last beat: Res_out <= acc + prod + (cas_en ? Res_cas_in : 0); acc <= 0; Res_valid <= 1.
- Res_cas_in is sampled on the stage-2 last-beat edge.
- Res_valid clears on Res_ready when no new result is being written on that edge.
- Latency: Res_valid is high in the cycle after the 2nd rising edge following the acceptance of the last beat. Throughput is 1 beat per cycle.
- Product arithmetic:
  - Mode 0: signed I × signed W, sign-extended to RES_W.
  - Mode 2: unsigned, zero-extended.
  - Mode 1: I and W each split into signed halves; prod = I_hi*W_hi + I_lo*W_lo, sign-extended.
- Accumulation wraps modulo 2**RES_W; there is no saturation.
- Config changes without a commit never affect the datapath.

Decomposition:
- Package mlblock_flex_pkg holds:
  - mode encodings (MODE_SIGNED=0, MODE_HALF=1, MODE_UNSIGNED=2);
  - CFG_BITS and the field offset/width constants;
  - a function computing the per-mode product.
- Sub-module mlblock_flex_lane: one lane's weight register, product register and accumulator, with adv/last/flush inputs.
- The top level holds the config chain, beat counter, handshake and output register.

Test Plan:
- Reset: after reset=1 for 2 cycles, Res_valid=0, Res_out=0, I_ready=1, W_out=0, config_out=0. After shifting 7 bits "1011001", config_out reproduces the stream 7 cycles later.
- Mode 0, acc_len=3, cas_en=0, W=2 on all lanes, 4 beats of I lanes {1,2,3,4} → Res_out lanes {8,16,24,32}, Res_valid 1 cycle, 2 edges after the last beat.
- Signs, I=0x80, W=0xFD, acc_len=0:
  - mode 0 → 384 (0x00000180);
  - mode 2 → 32384;
  - mode 1 (halves I: -8,0; W: -1,-3) → 8.
- Back-pressure: hold Res_ready=0 during a result → Res_out stable, I_ready=0, no beat lost. Releasing after 5 cycles gives the correct next result on a continuous stream.
- Cascade: cas_en=1, Res_cas_in=100 per lane with the test-2 stimulus → {108,116,124,132}.
- Mid-accumulation commit: commit after 2 of 4 beats → partial sum discarded, and the next 4 beats give a clean result. config_en and config_commit in the same cycle commit the old shadow.
